clksw_requester: RTL and testbench

- Requester side of the CPU clock-switch handshake.
- Decides when the CPU runs from the fast clock and when it runs from the host (slow) clock, based on upstream host-access decode and configuration.
- Drives hsclk_sel and cpuclk_div_sel into the clock controller, and consumes that controller's hsclk_selected / lsclk_selected feedback after resynchronisation.
- Owns the dwell policy (anti-thrash), the divider-change safety rule and the handshake timeout.

---
 rtl/clksw_requester_if.sv | 28 ++
 rtl/clksw_requester.sv | 156 +++++++++++++++
 tb/tb_clksw_requester.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clksw_requester_if.sv
// Handshake bundle between the CPU clock-switch requester and its neighbours:
// upstream decode/config in, clock-controller request out, controller feedback in.
interface clksw_requester_if;
    logic       host_access_req;
    logic       cfg_fast_en;
    logic [1:0] cfg_div_sel;
    logic       err_clr;
    logic       hsclk_selected_in;
    logic       lsclk_selected_in;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       fast_active;
    logic       switch_busy;
    logic       timeout_err;

    // master: upstream decode, software config and the clock controller
    modport master (
        output host_access_req, cfg_fast_en, cfg_div_sel, err_clr,
        output hsclk_selected_in, lsclk_selected_in,
        input  hsclk_sel, cpuclk_div_sel, fast_active, switch_busy, timeout_err
    );

    modport slave (
        input  host_access_req, cfg_fast_en, cfg_div_sel, err_clr,
        input  hsclk_selected_in, lsclk_selected_in,
        output hsclk_sel, cpuclk_div_sel, fast_active, switch_busy, timeout_err
    );
endinterface

// File: rtl/clksw_requester.sv
// Requester side of the CPU fast/slow clock-switch handshake: dwell policy,
// divider latch on request, feedback resynchronisation and handshake timeout.
module clksw_requester #(
    parameter int SYNC_STAGES  = 2,
    parameter int DWELL_CYCLES = 16,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 8
) (
    input  logic               hsclk_in,
    input  logic               rst_b,
    clksw_requester_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_SLOW     = 2'd0,
        ST_REQ_FAST = 2'd1,
        ST_FAST     = 2'd2,
        ST_REQ_SLOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_INIT = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_hs_sync;
    logic [SYNC_STAGES-1:0] r_ls_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;

    state_t           r_state;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] r_tmo;
    logic             r_hsel;
    logic [1:0]       r_div;
    logic             r_fast;
    logic             r_busy;
    logic             r_err;

    logic             w_hs_ack;
    logic             w_ls_ack;
    logic             w_leave;
    logic             w_dwell_go;
    logic [CNT_W-1:0] w_tmo_inc;

    // Feedback is not trusted until every sync stage has sampled the real
    // inputs, so the reset preload never counts as an acknowledge.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_hs_sync  <= '0;
            r_ls_sync  <= '1;
            r_sync_vld <= '0;
        end else begin
            r_hs_sync  <= {r_hs_sync[SYNC_STAGES-2:0], bus.hsclk_selected_in};
            r_ls_sync  <= {r_ls_sync[SYNC_STAGES-2:0], bus.lsclk_selected_in};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_hs_ack   = r_sync_vld[SYNC_STAGES-1] &  r_hs_sync[SYNC_STAGES-1] & ~r_ls_sync[SYNC_STAGES-1];
    assign w_ls_ack   = r_sync_vld[SYNC_STAGES-1] &  r_ls_sync[SYNC_STAGES-1] & ~r_hs_sync[SYNC_STAGES-1];
    assign w_leave    = bus.host_access_req | ~bus.cfg_fast_en;
    assign w_dwell_go = ~w_leave & w_ls_ack;
    assign w_tmo_inc  = (r_tmo == CNT_SAT) ? r_tmo : r_tmo + CNT_ONE;

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_SLOW;
            r_dwell <= DWELL_INIT;
            r_tmo   <= '0;
            r_hsel  <= 1'b0;
            r_div   <= 2'b00;
            r_fast  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // a timeout set later in this block overrides the clear
            if (bus.err_clr) r_err <= 1'b0;

            case (r_state)
                ST_SLOW: begin
                    if (!w_dwell_go) begin
                        r_dwell <= DWELL_INIT;
                    end else if (r_dwell == '0) begin
                        r_div   <= bus.cfg_div_sel;
                        r_hsel  <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= ST_REQ_FAST;
                        r_busy  <= 1'b1;
                    end else begin
                        r_dwell <= r_dwell - CNT_ONE;
                    end
                end

                ST_REQ_FAST: begin
                    if (w_hs_ack) begin
                        r_tmo   <= w_tmo_inc;
                        r_state <= ST_FAST;
                        r_fast  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_leave) begin
                        r_hsel  <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= ST_REQ_SLOW;
                    end else if (r_tmo == TMO_MAX) begin
                        r_err   <= 1'b1;
                        r_hsel  <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= ST_REQ_SLOW;
                    end else begin
                        r_tmo   <= w_tmo_inc;
                    end
                end

                ST_FAST: begin
                    if (w_leave) begin
                        r_hsel  <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= ST_REQ_SLOW;
                        r_fast  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_REQ_SLOW: begin
                    // stay here until the controller confirms slow; never re-request blind
                    if (w_ls_ack) begin
                        r_dwell <= DWELL_INIT;
                        r_state <= ST_SLOW;
                        r_busy  <= 1'b0;
                    end else if (r_tmo == TMO_MAX) begin
                        r_err   <= 1'b1;
                        r_tmo   <= '0;
                    end else begin
                        r_tmo   <= w_tmo_inc;
                    end
                end

                default: begin
                    r_state <= ST_SLOW;
                    r_dwell <= DWELL_INIT;
                    r_tmo   <= '0;
                    r_hsel  <= 1'b0;
                    r_fast  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hsclk_sel      = r_hsel;
    assign bus.cpuclk_div_sel = r_div;
    assign bus.fast_active    = r_fast;
    assign bus.switch_busy    = r_busy;
    assign bus.timeout_err    = r_err;

endmodule

// File: tb/tb_clksw_requester.sv
// Directed walk through the clock-switch handshake followed by a randomized
// phase, all outputs compared every cycle against a behavioural model.
module tb_clksw_requester;
    localparam int SYNC  = 2;
    localparam int DWELL = 16;
    localparam int TMO   = 255;
    localparam int CW    = 8;

    localparam int M_SLOW = 0, M_RF = 1, M_FAST = 2, M_RS = 3;

    logic hsclk_in = 1'b0;
    logic rst_b    = 1'b0;

    clksw_requester_if bus();

    clksw_requester #(
        .SYNC_STAGES(SYNC), .DWELL_CYCLES(DWELL), .TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .hsclk_in (hsclk_in),
        .rst_b    (rst_b),
        .bus      (bus)
    );

    always #5 hsclk_in = ~hsclk_in;

    int n_chk  = 0;
    int n_pass = 0;

    // model: mode, counters, expected outputs, and the feedback seen by the requester
    int              m_mode, m_dwell, m_tmo, m_seen;
    logic            m_hsel, m_fast, m_busy, m_err;
    logic [1:0]      m_div;
    logic [SYNC-1:0] m_hp, m_lp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_mode = M_SLOW; m_dwell = DWELL; m_tmo = 0; m_seen = 0;
        m_hsel = 0; m_fast = 0; m_busy = 0; m_err = 0; m_div = 2'b00;
        m_hp = '0; m_lp = '1;
    endtask

    function automatic logic m_hs_ack();
        return (m_seen >= SYNC) && m_hp[SYNC-1] && !m_lp[SYNC-1];
    endfunction

    function automatic logic m_ls_ack();
        return (m_seen >= SYNC) && m_lp[SYNC-1] && !m_hp[SYNC-1];
    endfunction

    task automatic model_step();
        logic ha, la, leave, set_err;
        ha      = m_hs_ack();
        la      = m_ls_ack();
        leave   = bus.host_access_req || !bus.cfg_fast_en;
        set_err = 1'b0;
        m_hp = {m_hp[SYNC-2:0], bus.hsclk_selected_in};
        m_lp = {m_lp[SYNC-2:0], bus.lsclk_selected_in};
        if (m_seen < SYNC) m_seen++;
        case (m_mode)
            M_SLOW: begin
                if (leave || !la) m_dwell = DWELL;
                else if (m_dwell == 0) begin
                    m_div = bus.cfg_div_sel; m_hsel = 1; m_tmo = 0; m_mode = M_RF;
                end else m_dwell--;
            end
            M_RF: begin
                if (ha) m_mode = M_FAST;
                else if (leave) begin m_hsel = 0; m_tmo = 0; m_mode = M_RS; end
                else if (m_tmo == TMO) begin set_err = 1; m_hsel = 0; m_tmo = 0; m_mode = M_RS; end
                else m_tmo++;
            end
            M_FAST: begin
                if (leave) begin m_hsel = 0; m_tmo = 0; m_mode = M_RS; end
            end
            default: begin
                if (la) begin m_dwell = DWELL; m_mode = M_SLOW; end
                else if (m_tmo == TMO) begin set_err = 1; m_tmo = 0; end
                else m_tmo++;
            end
        endcase
        m_err  = set_err ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
        m_fast = (m_mode == M_FAST);
        m_busy = (m_mode == M_RF) || (m_mode == M_RS);
    endtask

    task automatic cyc();
        @(posedge hsclk_in);
        model_step();
        @(negedge hsclk_in);
        chk("hsclk_sel",   32'(bus.hsclk_sel),      32'(m_hsel));
        chk("div_sel",     32'(bus.cpuclk_div_sel), 32'(m_div));
        chk("fast_active", 32'(bus.fast_active),    32'(m_fast));
        chk("switch_busy", 32'(bus.switch_busy),    32'(m_busy));
        chk("timeout_err", 32'(bus.timeout_err),    32'(m_err));
    endtask

    task automatic wait_mode(input int md, input int lim, input string tag);
        int k;
        k = 0;
        while (m_mode != md && k < lim) begin cyc(); k++; end
        chk(tag, 32'(k < lim), 32'd1);
    endtask

    task automatic set_fb(input logic hs, input logic ls);
        bus.hsclk_selected_in = hs;
        bus.lsclk_selected_in = ls;
    endtask

    task automatic rand_phase(input int ncyc);
        int   frz;
        logic tgt, b;
        frz = 0;
        for (int i = 0; i < ncyc; i++) begin
            bus.host_access_req = ($urandom_range(0, 29) == 0);
            bus.cfg_fast_en     = ($urandom_range(0, 99) != 0);
            bus.cfg_div_sel     = 2'($urandom);
            bus.err_clr         = ($urandom_range(0, 39) == 0);
            tgt = m_hsel;
            // controller stand-in: passes through a settling state, sometimes stalls
            if (frz > 0) frz--;
            else if ($urandom_range(0, 799) == 0) frz = 300;
            else if ({bus.hsclk_selected_in, bus.lsclk_selected_in} != {tgt, ~tgt} &&
                     $urandom_range(0, 2) == 0) begin
                if (bus.hsclk_selected_in != bus.lsclk_selected_in) begin
                    b = 1'($urandom_range(0, 1));
                    set_fb(b, b);
                end else set_fb(tgt, ~tgt);
            end
            cyc();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at %0t, limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.host_access_req = 0;
        bus.cfg_fast_en     = 1;
        bus.cfg_div_sel     = 2'b01;
        bus.err_clr         = 0;
        set_fb(0, 1);
        m_reset();

        // reset values
        repeat (2) @(negedge hsclk_in);
        chk("rst_hsel", 32'(bus.hsclk_sel),      32'd0);
        chk("rst_div",  32'(bus.cpuclk_div_sel), 32'd0);
        chk("rst_fast", 32'(bus.fast_active),    32'd0);
        chk("rst_busy", 32'(bus.switch_busy),    32'd0);
        chk("rst_err",  32'(bus.timeout_err),    32'd0);
        rst_b = 1;

        // first request: sync fill + dwell + 1 edges after release
        n = 0;
        while (bus.hsclk_sel !== 1'b1 && n < 40) begin cyc(); n++; end
        chk("first_req_latency", 32'(n), 32'(SYNC + DWELL + 1));
        chk("first_req_div",  32'(bus.cpuclk_div_sel), 32'd1);
        chk("first_req_busy", 32'(bus.switch_busy),    32'd1);

        // fast acknowledge, then divider change ignored in FAST
        set_fb(1, 0);
        repeat (SYNC + 1) cyc();
        chk("fast_after_ack", 32'(bus.fast_active), 32'd1);
        bus.cfg_div_sel = 2'b10;
        repeat (3) cyc();
        chk("div_held_in_fast", 32'(bus.cpuclk_div_sel), 32'd1);

        // one-cycle host access drops the fast request
        bus.host_access_req = 1;
        cyc();
        bus.host_access_req = 0;
        chk("host_drop_hsel", 32'(bus.hsclk_sel),   32'd0);
        chk("host_drop_busy", 32'(bus.switch_busy), 32'd1);
        set_fb(0, 1);
        wait_mode(M_SLOW, 20, "back_to_slow");
        chk("slow_busy", 32'(bus.switch_busy), 32'd0);

        // host access mid-dwell restarts the full dwell
        n = 0;
        while (m_dwell != 5 && n < 20) begin cyc(); n++; end
        chk("dwell_reach5", 32'(n < 20), 32'd1);
        bus.host_access_req = 1;
        cyc();
        bus.host_access_req = 0;
        n = 0;
        while (bus.hsclk_sel !== 1'b1 && n < 40) begin cyc(); n++; end
        chk("dwell_reload_latency", 32'(n), 32'(DWELL + 1));
        chk("div_latched_10", 32'(bus.cpuclk_div_sel), 32'd2);

        // REQ_FAST timeout with controller stuck settling
        set_fb(0, 0);
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 300) begin cyc(); n++; end
        chk("req_fast_timeout_cycles", 32'(n), 32'(TMO + 1));
        chk("timeout_hsel", 32'(bus.hsclk_sel),   32'd0);
        chk("timeout_busy", 32'(bus.switch_busy), 32'd1);
        bus.err_clr = 1;
        cyc();
        bus.err_clr = 0;
        chk("err_clr_alone_1", 32'(bus.timeout_err), 32'd0);
        n = 0;
        while (m_tmo != TMO && n < 300) begin cyc(); n++; end
        chk("req_slow_tmo_reach", 32'(n < 300), 32'd1);
        bus.err_clr = 1;
        cyc();
        bus.err_clr = 0;
        chk("err_set_beats_clr", 32'(bus.timeout_err), 32'd1);
        chk("still_req_slow",    32'(bus.switch_busy), 32'd1);
        bus.err_clr = 1;
        cyc();
        bus.err_clr = 0;
        chk("err_clr_alone_2", 32'(bus.timeout_err), 32'd0);

        // both feedback high is settling, never an ack
        set_fb(0, 1);
        wait_mode(M_SLOW, 20, "recover_slow");
        wait_mode(M_RF, 40, "rerequest");
        set_fb(1, 1);
        repeat (10) cyc();
        chk("both_high_no_fast", 32'(bus.fast_active), 32'd0);
        chk("both_high_busy",    32'(bus.switch_busy), 32'd1);

        // ack and host access on the same edge: FAST first, then REQ_SLOW
        set_fb(1, 0);
        n = 0;
        while (!m_hs_ack() && n < 10) begin cyc(); n++; end
        chk("ack_ready", 32'(n < 10), 32'd1);
        bus.host_access_req = 1;
        cyc();
        chk("ack_beats_abort", 32'(bus.fast_active), 32'd1);
        cyc();
        bus.host_access_req = 0;
        chk("then_req_slow_fast", 32'(bus.fast_active), 32'd0);
        chk("then_req_slow_hsel", 32'(bus.hsclk_sel),   32'd0);
        chk("then_req_slow_busy", 32'(bus.switch_busy), 32'd1);

        // asynchronous reset from FAST
        set_fb(0, 1);
        wait_mode(M_SLOW, 20, "pre_rst_slow");
        wait_mode(M_RF, 40, "pre_rst_req");
        set_fb(1, 0);
        wait_mode(M_FAST, 20, "pre_rst_fast");
        #1 rst_b = 0;
        #1;
        chk("arst_hsel", 32'(bus.hsclk_sel),      32'd0);
        chk("arst_div",  32'(bus.cpuclk_div_sel), 32'd0);
        chk("arst_fast", 32'(bus.fast_active),    32'd0);
        chk("arst_busy", 32'(bus.switch_busy),    32'd0);
        chk("arst_err",  32'(bus.timeout_err),    32'd0);
        m_reset();
        @(negedge hsclk_in);
        rst_b = 1;

        rand_phase(4000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
